// File: rtl/msrv32_csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: addresses, Zicsr funct3
// encodings, mstatus layout and the read-modify-write helper.
package msrv32_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    typedef enum logic [2:0] {
        OP_NONE = 3'b000,
        OP_RW   = 3'b001,
        OP_RS   = 3'b010,
        OP_RC   = 3'b011,
        OP_RWI  = 3'b101,
        OP_RSI  = 3'b110,
        OP_RCI  = 3'b111
    } csr_op_e;

    localparam int          MSTATUS_MIE    = 3;
    localparam int          MSTATUS_MPIE   = 7;
    localparam logic [1:0]  MSTATUS_MPP_M  = 2'b11;
    localparam logic [31:0] MIE_WRITE_MASK = 32'h0000_0888;
    localparam logic [31:0] ALIGN4_MASK    = 32'hFFFF_FFFC;

    function automatic logic [31:0] mstatus_image(input logic mie, input logic mpie);
        logic [31:0] value;
        value               = '0;
        value[12:11]        = MSTATUS_MPP_M;
        value[MSTATUS_MIE]  = mie;
        value[MSTATUS_MPIE] = mpie;
        return value;
    endfunction

    function automatic logic [31:0] rmw_value(input csr_op_e op, input logic [31:0] old_value,
                                              input logic [31:0] src);
        logic [31:0] value;
        value = old_value;
        case (op)
            OP_RW, OP_RWI: value = src;
            OP_RS, OP_RSI: value = old_value | src;
            OP_RC, OP_RCI: value = old_value & ~src;
            default:       value = old_value;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/msrv32_csr_counter.sv
// 64-bit free-running counter with independent half writes; a write to either
// half holds the whole counter for that cycle instead of incrementing.
module msrv32_csr_counter
    import msrv32_csr_pkg::*;
(
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        inc_in,
    input  logic        wr_lo_in,
    input  logic        wr_hi_in,
    input  logic [31:0] wr_data_in,
    output logic [63:0] count_out
);

    logic [63:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            count <= '0;
        end else if (wr_lo_in) begin
            count[31:0] <= wr_data_in;
        end else if (wr_hi_in) begin
            count[63:32] <= wr_data_in;
        end else if (inc_in) begin
            count <= count + 64'd1;
        end
    end

    assign count_out = count;

endmodule

// File: rtl/msrv32_csr_unit.sv
// Stage-3 machine-mode CSR file: Zicsr read-modify-write, trap entry/MRET
// state, and the mcycle/minstret counters with their user read-only shadows.
module msrv32_csr_unit
    import msrv32_csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'h0000_0000,
    parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [11:0] csr_addr_in,
    input  logic [2:0]  csr_op_in,
    input  logic        csr_wr_en_in,
    input  logic [31:0] rs1_in,
    input  logic [31:0] imm_in,
    input  logic [31:0] pc_in,
    input  logic        instret_inc_in,
    input  logic        trap_taken_in,
    input  logic [31:0] trap_cause_in,
    input  logic [31:0] trap_val_in,
    input  logic        mret_in,
    output logic [31:0] csr_data_out,
    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out,
    output logic        mie_bit_out,
    output logic        illegal_csr_out
);

    localparam logic [31:0] MTVEC_RESET_ALIGNED = MTVEC_RESET & ALIGN4_MASK;

    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic [31:0] mie_reg;
    logic [31:0] mtvec_reg;
    logic [31:0] mscratch_reg;
    logic [31:0] mepc_reg;
    logic [31:0] mcause_reg;
    logic [31:0] mtval_reg;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    csr_op_e     op;
    logic [31:0] src;
    logic [31:0] read_data;
    logic [31:0] new_value;
    logic        implemented;
    logic        read_only;
    logic        write_attempt;
    logic        illegal;
    logic        do_write;
    logic        unused_imm;

    assign op         = csr_op_e'(csr_op_in);
    assign src        = csr_op_in[2] ? {27'b0, imm_in[4:0]} : rs1_in;
    assign unused_imm = ^imm_in[31:5];
    assign read_only  = (csr_addr_in[11:10] == 2'b11);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        read_data   = '0;
        implemented = 1'b1;
        case (csr_addr_in)
            CSR_MSTATUS:                read_data = mstatus_image(mstatus_mie, mstatus_mpie);
            CSR_MISA:                   read_data = MISA_VAL;
            CSR_MIE:                    read_data = mie_reg;
            CSR_MTVEC:                  read_data = mtvec_reg;
            CSR_MSCRATCH:               read_data = mscratch_reg;
            CSR_MEPC:                   read_data = mepc_reg;
            CSR_MCAUSE:                 read_data = mcause_reg;
            CSR_MTVAL:                  read_data = mtval_reg;
            CSR_MIP:                    read_data = '0;
            CSR_MCYCLE, CSR_CYCLE:      read_data = mcycle[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:    read_data = mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET:  read_data = minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: read_data = minstret[63:32];
            CSR_MHARTID:                read_data = HART_ID;
            default:                    implemented = 1'b0;
        endcase
    end

    // Set/clear forms with a zero source are pure reads and never count as writes.
    always_comb begin
        write_attempt = 1'b0;
        case (op)
            OP_RW, OP_RWI:                 write_attempt = 1'b1;
            OP_RS, OP_RSI, OP_RC, OP_RCI:  write_attempt = (src != '0);
            default:                       write_attempt = 1'b0;
        endcase
    end

    assign illegal   = csr_wr_en_in && (!implemented || (read_only && write_attempt));
    assign do_write  = csr_wr_en_in && !illegal && write_attempt && !trap_taken_in;
    assign new_value = rmw_value(op, read_data, src);

    msrv32_csr_counter u_mcycle (
        .clk_in     (clk_in),
        .reset_in   (reset_in),
        .inc_in     (1'b1),
        .wr_lo_in   (do_write && (csr_addr_in == CSR_MCYCLE)),
        .wr_hi_in   (do_write && (csr_addr_in == CSR_MCYCLEH)),
        .wr_data_in (new_value),
        .count_out  (mcycle)
    );

    msrv32_csr_counter u_minstret (
        .clk_in     (clk_in),
        .reset_in   (reset_in),
        .inc_in     (instret_inc_in),
        .wr_lo_in   (do_write && (csr_addr_in == CSR_MINSTRET)),
        .wr_hi_in   (do_write && (csr_addr_in == CSR_MINSTRETH)),
        .wr_data_in (new_value),
        .count_out  (minstret)
    );

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_reg      <= '0;
            mtvec_reg    <= MTVEC_RESET_ALIGNED;
            mscratch_reg <= '0;
            mepc_reg     <= '0;
            mcause_reg   <= '0;
            mtval_reg    <= '0;
        end else begin
            if (do_write) begin
                case (csr_addr_in)
                    CSR_MIE:      mie_reg      <= new_value & MIE_WRITE_MASK;
                    CSR_MTVEC:    mtvec_reg    <= new_value & ALIGN4_MASK;
                    CSR_MSCRATCH: mscratch_reg <= new_value;
                    CSR_MEPC:     mepc_reg     <= new_value & ALIGN4_MASK;
                    CSR_MCAUSE:   mcause_reg   <= new_value;
                    CSR_MTVAL:    mtval_reg    <= new_value;
                    default:      ;
                endcase
            end

            // Trap outranks MRET, which outranks a software write to mstatus.
            if (trap_taken_in) begin
                mepc_reg     <= pc_in & ALIGN4_MASK;
                mcause_reg   <= trap_cause_in;
                mtval_reg    <= trap_val_in;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (mret_in) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end else if (do_write && (csr_addr_in == CSR_MSTATUS)) begin
                mstatus_mie  <= new_value[MSTATUS_MIE];
                mstatus_mpie <= new_value[MSTATUS_MPIE];
            end
        end
    end

    assign csr_data_out    = read_data;
    assign illegal_csr_out = illegal;
    assign mtvec_out       = mtvec_reg;
    assign mepc_out        = mepc_reg;
    assign mie_bit_out     = mstatus_mie;

endmodule

// File: tb/tb_msrv32_csr_unit.sv
// Directed bench for msrv32_csr_unit: an architectural CSR model compared on
// every falling edge, plus hand-computed literal checks of each scenario.
module tb_msrv32_csr_unit;

    localparam logic [31:0] MTVEC_P = 32'h0000_1003;
    localparam logic [31:0] HART_P  = 32'h0000_0007;
    localparam logic [31:0] MISA_P  = 32'h4000_0100;

    localparam logic [2:0] RW = 3'b001, RS = 3'b010, RC = 3'b011;
    localparam logic [2:0] RWI = 3'b101, RSI = 3'b110, RCI = 3'b111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] addr = '0;
    logic [2:0]  op = '0;
    logic        wr_en = 1'b0;
    logic [31:0] rs1 = '0;
    logic [31:0] imm = '0;
    logic [31:0] pc = '0;
    logic        inc = 1'b0;
    logic        trap = 1'b0;
    logic [31:0] cause = '0;
    logic [31:0] tval = '0;
    logic        mret = 1'b0;
    logic [31:0] data_out;
    logic [31:0] mtvec_out;
    logic [31:0] mepc_out;
    logic        mie_bit;
    logic        illegal;

    int n_vec = 0;
    int n_bad = 0;
    bit model_valid = 1'b0;

    // Architectural model state
    bit          m_mie, m_mpie;
    logic [31:0] m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_cycle, m_instret;
    logic [31:0] ms_src, ms_old, ms_nv;
    bit          ms_wr;

    msrv32_csr_unit #(
        .MTVEC_RESET (MTVEC_P),
        .HART_ID     (HART_P),
        .MISA_VAL    (MISA_P)
    ) dut (
        .clk_in          (clk),
        .reset_in        (rst),
        .csr_addr_in     (addr),
        .csr_op_in       (op),
        .csr_wr_en_in    (wr_en),
        .rs1_in          (rs1),
        .imm_in          (imm),
        .pc_in           (pc),
        .instret_inc_in  (inc),
        .trap_taken_in   (trap),
        .trap_cause_in   (cause),
        .trap_val_in     (tval),
        .mret_in         (mret),
        .csr_data_out    (data_out),
        .mtvec_out       (mtvec_out),
        .mepc_out        (mepc_out),
        .mie_bit_out     (mie_bit),
        .illegal_csr_out (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_impl(input logic [11:0] a);
        case (a)
            12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
            12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hC02, 12'hC80, 12'hC82,
            12'hF14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h0000_1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mie ? 32'h8 : 32'h0);
            12'h301: return MISA_P;
            12'h304: return m_mie_reg;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'hB00, 12'hC00: return m_cycle[31:0];
            12'hB80, 12'hC80: return m_cycle[63:32];
            12'hB02, 12'hC02: return m_instret[31:0];
            12'hB82, 12'hC82: return m_instret[63:32];
            12'hF14: return HART_P;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_src();
        return op[2] ? {27'b0, imm[4:0]} : rs1;
    endfunction

    function automatic bit model_attempt();
        if (op[1:0] == 2'b01) return 1'b1;
        if (op[1:0] == 2'b10 || op[1:0] == 2'b11) return model_src() != 32'h0;
        return 1'b0;
    endfunction

    function automatic bit model_illegal();
        if (!wr_en) return 1'b0;
        return !model_impl(addr) || (addr[11:10] == 2'b11 && model_attempt());
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mie = 0; m_mpie = 0;
            m_mie_reg = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
            m_mtvec = MTVEC_P & 32'hFFFF_FFFC;
            m_cycle = 0; m_instret = 0;
            model_valid = 1'b1;
        end else begin
            ms_src = model_src();
            ms_old = model_read(addr);
            case (op[1:0])
                2'b01:   ms_nv = ms_src;
                2'b10:   ms_nv = ms_old | ms_src;
                2'b11:   ms_nv = ms_old & ~ms_src;
                default: ms_nv = ms_old;
            endcase
            ms_wr = wr_en && !model_illegal() && model_attempt() && !trap;

            if (ms_wr && addr == 12'hB00)      m_cycle[31:0] = ms_nv;
            else if (ms_wr && addr == 12'hB80) m_cycle[63:32] = ms_nv;
            else                               m_cycle = m_cycle + 1;
            if (ms_wr && addr == 12'hB02)      m_instret[31:0] = ms_nv;
            else if (ms_wr && addr == 12'hB82) m_instret[63:32] = ms_nv;
            else if (inc)                      m_instret = m_instret + 1;

            if (ms_wr) begin
                case (addr)
                    12'h300: begin m_mie = ms_nv[3]; m_mpie = ms_nv[7]; end
                    12'h304: m_mie_reg = ms_nv & 32'h888;
                    12'h305: m_mtvec = ms_nv & 32'hFFFF_FFFC;
                    12'h340: m_mscratch = ms_nv;
                    12'h341: m_mepc = ms_nv & 32'hFFFF_FFFC;
                    12'h342: m_mcause = ms_nv;
                    12'h343: m_mtval = ms_nv;
                    default: ;
                endcase
            end
            if (trap) begin
                m_mepc = pc & 32'hFFFF_FFFC;
                m_mcause = cause;
                m_mtval = tval;
                m_mpie = m_mie;
                m_mie = 0;
            end else if (mret) begin
                m_mie = m_mpie;
                m_mpie = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("cyc_data", data_out, model_read(addr));
            check("cyc_illegal", {31'b0, illegal}, {31'b0, model_illegal()});
            check("cyc_mtvec", mtvec_out, m_mtvec);
            check("cyc_mepc", mepc_out, m_mepc);
            check("cyc_mie_bit", {31'b0, mie_bit}, {31'b0, m_mie});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input string name, input logic [11:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(name, data_out, exp);
    endtask

    task automatic csr(input logic [2:0] o, input logic [11:0] a, input logic [31:0] r,
                       input logic [31:0] im);
        op = o; addr = a; rs1 = r; imm = im; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        step();
        step();
        peek("rst_mtvec", 12'h305, 32'h0000_1000);
        peek("rst_mstatus", 12'h300, 32'h0000_1800);
        peek("rst_mcycle", 12'hB00, 32'h0);
        check("rst_illegal", {31'b0, illegal}, 32'h0);
        rst = 1'b0;

        csr(RW, 12'h340, 32'hDEAD_BEEF, 32'h0);
        peek("rw_mscratch", 12'h340, 32'hDEAD_BEEF);
        csr(RCI, 12'h340, 32'h0, 32'hFFFF_FF0F);
        peek("rci_mscratch", 12'h340, 32'hDEAD_BEE0);

        csr(RS, 12'h300, 32'h0, 32'h0);
        peek("rs0_mstatus", 12'h300, 32'h0000_1800);
        check("rs0_mie_bit", {31'b0, mie_bit}, 32'h0);
        csr(RS, 12'h300, 32'h8, 32'h0);
        peek("rs8_mstatus", 12'h300, 32'h0000_1808);
        check("rs8_mie_bit", {31'b0, mie_bit}, 32'h1);

        csr(RW, 12'hB00, 32'hFFFF_FFFF, 32'h0);
        csr(RW, 12'hB80, 32'h0, 32'h0);
        step();
        step();
        peek("mcycleh_carry", 12'hB80, 32'h1);
        peek("mcycle_carry", 12'hB00, 32'h1);
        peek("cycle_shadow", 12'hC00, 32'h1);

        trap = 1'b1; pc = 32'h0000_0106; cause = 32'h0000_000B; tval = 32'hDEAD_0001;
        csr(RW, 12'h340, 32'h1234_5678, 32'h0);
        trap = 1'b0;
        peek("trap_mepc", 12'h341, 32'h0000_0104);
        peek("trap_mstatus", 12'h300, 32'h0000_1880);
        peek("trap_mscratch", 12'h340, 32'hDEAD_BEE0);
        check("trap_mie_bit", {31'b0, mie_bit}, 32'h0);
        step();
        peek("trap_mcause", 12'h342, 32'h0000_000B);
        peek("trap_mtval", 12'h343, 32'hDEAD_0001);
        mret = 1'b1;
        step();
        mret = 1'b0;
        peek("mret_mstatus", 12'h300, 32'h0000_1888);
        check("mret_mie_bit", {31'b0, mie_bit}, 32'h1);

        trap = 1'b1; mret = 1'b1; pc = 32'h0000_0203;
        step();
        trap = 1'b0; mret = 1'b0;
        peek("trapmret_mstatus", 12'h300, 32'h0000_1880);
        peek("trapmret_mepc", 12'h341, 32'h0000_0200);

        step();
        op = RW; addr = 12'hC00; rs1 = 32'h5; wr_en = 1'b1;
        #1 check("ro_write_illegal", {31'b0, illegal}, 32'h1);
        addr = 12'h7C0;
        #1 check("unimpl_illegal", {31'b0, illegal}, 32'h1);
        check("unimpl_data", data_out, 32'h0);
        step();
        wr_en = 1'b0;
        #1 check("idle_not_illegal", {31'b0, illegal}, 32'h0);
        op = RS; addr = 12'hC00; rs1 = 32'h0; wr_en = 1'b1;
        #1 check("ro_read_legal", {31'b0, illegal}, 32'h0);
        step();
        wr_en = 1'b0;
        peek("after_illegal_mscratch", 12'h340, 32'hDEAD_BEE0);

        csr(RW, 12'h304, 32'hFFFF_FFFF, 32'h0);
        peek("mie_mask", 12'h304, 32'h0000_0888);
        csr(RW, 12'h305, 32'hABCD_0007, 32'h0);
        peek("mtvec_align", 12'h305, 32'hABCD_0004);
        check("mtvec_out", mtvec_out, 32'hABCD_0004);
        peek("mhartid", 12'hF14, HART_P);
        step();
        peek("misa", 12'h301, MISA_P);
        peek("mip", 12'h344, 32'h0);

        csr(RW, 12'hB02, 32'h10, 32'h0);
        inc = 1'b1;
        step(); step(); step();
        inc = 1'b0;
        peek("minstret_inc", 12'hB02, 32'h13);
        peek("instret_shadow", 12'hC02, 32'h13);
        peek("instreth_shadow", 12'hC82, 32'h0);
        inc = 1'b1;
        csr(RWI, 12'hB02, 32'h0, 32'h5);
        inc = 1'b0;
        peek("minstret_wr_blocks", 12'hB02, 32'h5);
        csr(RW, 12'hB82, 32'hFFFF_FFFF, 32'h0);
        csr(RW, 12'hB02, 32'hFFFF_FFFF, 32'h0);
        inc = 1'b1;
        step();
        inc = 1'b0;
        peek("minstret_wrap_lo", 12'hB02, 32'h0);
        peek("minstret_wrap_hi", 12'hB82, 32'h0);
        csr(RC, 12'h340, 32'h0000_00F0, 32'h0);
        peek("rc_mscratch", 12'h340, 32'hDEAD_BE00);
        csr(RSI, 12'h340, 32'h0, 32'h3);
        peek("rsi_mscratch", 12'h340, 32'hDEAD_BE03);

        op = RW; addr = 12'h340; rs1 = 32'h1234; wr_en = 1'b1; rst = 1'b1;
        step();
        wr_en = 1'b0;
        peek("midrst_mscratch", 12'h340, 32'h0);
        peek("midrst_mtvec", 12'h305, 32'h0000_1000);
        peek("midrst_mcycle", 12'hB00, 32'h0);
        check("midrst_mepc_out", mepc_out, 32'h0);
        rst = 1'b0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
